// File: rtl/reg_wb_pkg.sv
// -----------------------------------------------------------------------------
// reg_wb_pkg
//   Shared definitions for the register write-back controller:
//     - 4-bit opcode encodings of the instruction set
//     - instruction class and controller state enums
//     - classify(): opcode -> write-back class
//   Imported by reg_wb_ctrl and reg_file_16x16.
// -----------------------------------------------------------------------------
package reg_wb_pkg;

    localparam int OPC_W = 4;

    // R-type: destination in the rd field
    localparam logic [OPC_W-1:0] OP_ADDREG   = 4'b1000;
    localparam logic [OPC_W-1:0] OP_SUBREG   = 4'b1100;
    localparam logic [OPC_W-1:0] OP_LNAND    = 4'b1011;
    localparam logic [OPC_W-1:0] OP_LOR      = 4'b1111;
    localparam logic [OPC_W-1:0] OP_SHIFT    = 4'b0000;

    // I-type: destination in the rt field
    localparam logic [OPC_W-1:0] OP_ADDSEIMD = 4'b1001;
    localparam logic [OPC_W-1:0] OP_LNANDIMD = 4'b1010;
    localparam logic [OPC_W-1:0] OP_SUBSEIMD = 4'b1101;
    localparam logic [OPC_W-1:0] OP_LORIMD   = 4'b1110;
    localparam logic [OPC_W-1:0] OP_LUI      = 4'b0111;
    localparam logic [OPC_W-1:0] OP_LLI      = 4'b0110;

    // Load: destination in rt, data from memory
    localparam logic [OPC_W-1:0] OP_LWD      = 4'b0001;

    // No register write
    localparam logic [OPC_W-1:0] OP_STRWD    = 4'b0010;
    localparam logic [OPC_W-1:0] OP_BRNCHEQ  = 4'b0100;
    localparam logic [OPC_W-1:0] OP_BRNCHNEQ = 4'b0101;
    localparam logic [OPC_W-1:0] OP_JMP      = 4'b0011;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_NOWR,
        CLS_ILL
    } wb_class_e;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT_MEM
    } wb_state_e;

    // The current map covers all 16 encodings; CLS_ILL is kept so that a
    // future encoding removed from the map is reported instead of silently
    // retired as something else.
    function automatic wb_class_e classify(input logic [OPC_W-1:0] op);
        wb_class_e cls;
        case (op)
            OP_ADDREG, OP_SUBREG, OP_LNAND, OP_LOR, OP_SHIFT:
                cls = CLS_R;
            OP_ADDSEIMD, OP_LNANDIMD, OP_SUBSEIMD, OP_LORIMD, OP_LUI, OP_LLI:
                cls = CLS_I;
            OP_LWD:
                cls = CLS_LOAD;
            OP_STRWD, OP_BRNCHEQ, OP_BRNCHNEQ, OP_JMP:
                cls = CLS_NOWR;
            default:
                cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/reg_wb_ctrl_regfile.sv
// -----------------------------------------------------------------------------
// reg_file_16x16
//   16 x DATA_W register storage with one write port and two combinational
//   read ports. Register 0 is hardwired to zero: writes to it are dropped and
//   reads of it return 0.
//
//   Optional feature (macro REG_WB_BYPASS_EN):
//     defined   - write-through bypass: a read of the address being written
//                 returns the write data in the same cycle (never for r0).
//     undefined - reads return the stored value; a write becomes visible the
//                 cycle after the write strobe.
//
//   Ports:
//     clk, reset          clock, synchronous active-high reset (clears storage)
//     we, waddr, wdata    write strobe / address / data
//     raddr_a, rdata_a    read port A
//     raddr_b, rdata_b    read port B
// -----------------------------------------------------------------------------
module reg_file_16x16
    import reg_wb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int NREGS = 1 << REG_AW;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] raw_a;
    logic [DATA_W-1:0] raw_b;
    logic              wr_live;

    // Storage is architectural state, so reset clears every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[waddr] <= wdata;
        end
    end

    // A write to r0 is a legal no-op on storage.
    assign wr_live = we && (waddr != '0);

    assign raw_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign raw_b = (raddr_b == '0) ? '0 : regs[raddr_b];

`ifdef REG_WB_BYPASS_EN
    // wr_live already excludes r0, so the zero rule holds under bypass too.
    assign rdata_a = (wr_live && (raddr_a == waddr)) ? wdata : raw_a;
    assign rdata_b = (wr_live && (raddr_b == waddr)) ? wdata : raw_b;
`else
    assign rdata_a = raw_a;
    assign rdata_b = raw_b;
`endif

endmodule

// File: rtl/reg_wb_ctrl.sv
// -----------------------------------------------------------------------------
// reg_wb_ctrl
//   Write-back end of the register-file datapath. Accepts one retiring
//   instruction per handshake, classifies its opcode, and writes the ALU
//   result (R/I-type) or the memory response (lwd) into the register file.
//   Store/branch/jump opcodes retire immediately without a write.
//
//   FSM: IDLE -> WRITE -> IDLE          (R-type, I-type)
//        IDLE -> WAIT_MEM -> WRITE -> IDLE  (lwd; waits indefinitely)
//        IDLE -> IDLE                   (no-write and illegal opcodes)
//
//   Optional feature: REG_WB_BYPASS_EN (see reg_file_16x16).
//
//   Ports:
//     clk, reset                   clock, synchronous active-high reset
//     wb_valid / wb_ready          instruction handshake (ready only in IDLE)
//     wb_opcode, wb_rd, wb_rt      opcode and destination fields
//     wb_alu_res                   ALU result
//     mem_rsp_valid, mem_rdata     load response (used only in WAIT_MEM)
//     rd_addr_a/b, rd_data_a/b     combinational read ports
//     wr_en_o, wr_addr_o           register write strobe / address
//     illegal_o                    one-cycle pulse after an unknown opcode
//     retired_cnt                  wrapping retired-instruction counter
// -----------------------------------------------------------------------------
module reg_wb_ctrl
    import reg_wb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [3:0]        wb_opcode,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [REG_AW-1:0] wb_rt,
    input  logic [DATA_W-1:0] wb_alu_res,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              wr_en_o,
    output logic [REG_AW-1:0] wr_addr_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  retired_cnt
);

    wb_state_e         state;
    wb_class_e         cls;
    logic              accept;
    logic              load_rsp;
    logic [REG_AW-1:0] dst_q;
    logic [DATA_W-1:0] data_q;

    assign wb_ready = (state == IDLE);
    assign accept   = wb_valid && wb_ready;
    assign cls      = classify(wb_opcode);
    assign load_rsp = (state == WAIT_MEM) && mem_rsp_valid;

    // Control path: state, write strobe/address, illegal pulse, counter.
    // wr_en_o is registered on the transition into WRITE, so it is high for
    // exactly the WRITE cycle and the storage updates at the end of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_en_o     <= 1'b0;
            wr_addr_o   <= '0;
            illegal_o   <= 1'b0;
            retired_cnt <= '0;
        end else begin
            wr_en_o   <= 1'b0;
            illegal_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cls)
                            CLS_R: begin
                                wr_en_o   <= 1'b1;
                                wr_addr_o <= wb_rd;
                                state     <= WRITE;
                            end
                            CLS_I: begin
                                wr_en_o   <= 1'b1;
                                wr_addr_o <= wb_rt;
                                state     <= WRITE;
                            end
                            CLS_LOAD: begin
                                state <= WAIT_MEM;
                            end
                            CLS_NOWR: begin
                                retired_cnt <= retired_cnt + CNT_W'(1);
                            end
                            default: begin
                                illegal_o   <= 1'b1;
                                retired_cnt <= retired_cnt + CNT_W'(1);
                            end
                        endcase
                    end
                end
                WRITE: begin
                    retired_cnt <= retired_cnt + CNT_W'(1);
                    state       <= IDLE;
                end
                WAIT_MEM: begin
                    // No timeout: the memory system guarantees a response.
                    if (mem_rsp_valid) begin
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= dst_q;
                        state     <= WRITE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Data path: destination and write data captured without reset; they are
    // only consumed once the control path has marked them valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            dst_q  <= (cls == CLS_R) ? wb_rd : wb_rt;
            data_q <= wb_alu_res;
        end else if (load_rsp) begin
            data_q <= mem_rdata;
        end
    end

    reg_file_16x16 #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (wr_en_o),
        .waddr   (wr_addr_o),
        .wdata   (data_q),
        .raddr_a (rd_addr_a),
        .rdata_a (rd_data_a),
        .raddr_b (rd_addr_b),
        .rdata_b (rd_data_b)
    );

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_wb_ctrl
//   Self-checking bench for reg_wb_ctrl: a vector table of single-instruction
//   retirements plus hand-written multi-cycle sequences (load wait, back-to-back
//   no-write accepts, bypass, reset during WAIT_MEM, counter wrap). Every write
//   strobe is matched against a scoreboard and the written register is read
//   back on port B the following cycle.
// -----------------------------------------------------------------------------
module tb_reg_wb_ctrl;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int CNT_W  = 8;
    localparam int NV     = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              wb_valid;
    logic              wb_ready;
    logic [3:0]        wb_opcode;
    logic [REG_AW-1:0] wb_rd;
    logic [REG_AW-1:0] wb_rt;
    logic [DATA_W-1:0] wb_alu_res;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic [REG_AW-1:0] rd_addr_a;
    logic [REG_AW-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              wr_en_o;
    logic [REG_AW-1:0] wr_addr_o;
    logic              illegal_o;
    logic [CNT_W-1:0]  retired_cnt;

    always #5 clk = ~clk;

    reg_wb_ctrl #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_opcode     (wb_opcode),
        .wb_rd         (wb_rd),
        .wb_rt         (wb_rt),
        .wb_alu_res    (wb_alu_res),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .rd_addr_a     (rd_addr_a),
        .rd_addr_b     (rd_addr_b),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b),
        .wr_en_o       (wr_en_o),
        .wr_addr_o     (wr_addr_o),
        .illegal_o     (illegal_o),
        .retired_cnt   (retired_cnt)
    );

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rt;
        logic [15:0] alu;
        bit          wr;
        logic [3:0]  addr;
    } vec_t;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } exp_t;

    vec_t       vec [NV];
    exp_t       sb [$];
    int         checks   = 0;
    int         failures = 0;
    int         exp_cnt  = 0;

    logic              mon_sel;
    logic [REG_AW-1:0] mon_addr;
    logic [DATA_W-1:0] mon_exp;
    logic [REG_AW-1:0] scan_b;

    assign rd_addr_b = mon_sel ? mon_addr : scan_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [3:0] op, input logic [3:0] rd,
                          input logic [3:0] rt, input logic [15:0] alu);
        int n = 0;
        while (!wb_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_ready", {31'd0, wb_ready}, 32'd1);
        wb_valid   = 1'b1;
        wb_opcode  = op;
        wb_rd      = rd;
        wb_rt      = rt;
        wb_alu_res = alu;
        tick();
        wb_valid   = 1'b0;
    endtask

    task automatic bump_cnt();
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    endtask

    // Hang guard: only fires if a wait above is broken.
    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] nowr_ops [3];
        exp_t       e;

        vec[0]  = '{4'b1000, 4'd3,  4'd9,  16'h1234, 1'b1, 4'd3};
        vec[1]  = '{4'b1100, 4'd4,  4'd1,  16'h0F0F, 1'b1, 4'd4};
        vec[2]  = '{4'b1011, 4'd6,  4'd2,  16'hA5A5, 1'b1, 4'd6};
        vec[3]  = '{4'b1111, 4'd8,  4'd3,  16'h8001, 1'b1, 4'd8};
        vec[4]  = '{4'b0000, 4'd9,  4'd4,  16'h7FFE, 1'b1, 4'd9};
        vec[5]  = '{4'b1001, 4'd1,  4'd10, 16'hC3C3, 1'b1, 4'd10};
        vec[6]  = '{4'b1010, 4'd2,  4'd11, 16'h0001, 1'b1, 4'd11};
        vec[7]  = '{4'b1101, 4'd3,  4'd12, 16'hFFFF, 1'b1, 4'd12};
        vec[8]  = '{4'b1110, 4'd4,  4'd13, 16'h5A5A, 1'b1, 4'd13};
        vec[9]  = '{4'b0111, 4'd5,  4'd14, 16'h00F0, 1'b1, 4'd14};
        vec[10] = '{4'b0110, 4'd6,  4'd15, 16'h0F00, 1'b1, 4'd15};
        vec[11] = '{4'b0010, 4'd5,  4'd5,  16'hDEAD, 1'b0, 4'd0};
        vec[12] = '{4'b0100, 4'd7,  4'd7,  16'hDEAD, 1'b0, 4'd0};
        vec[13] = '{4'b0101, 4'd1,  4'd1,  16'hDEAD, 1'b0, 4'd0};
        vec[14] = '{4'b0011, 4'd2,  4'd2,  16'hDEAD, 1'b0, 4'd0};
        vec[15] = '{4'b1001, 4'd5,  4'd0,  16'hFFFF, 1'b1, 4'd0};

        nowr_ops[0] = 4'b0010;
        nowr_ops[1] = 4'b0011;
        nowr_ops[2] = 4'b0100;

        mon_sel       = 1'b0;
        mon_addr      = '0;
        mon_exp       = '0;
        scan_b        = '0;
        reset         = 1'b1;
        wb_valid      = 1'b0;
        wb_opcode     = '0;
        wb_rd         = '0;
        wb_rt         = '0;
        wb_alu_res    = '0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        rd_addr_a     = '0;

        // Write monitor: match each strobe with the scoreboard, read back next cycle.
        fork
            forever begin
                @(negedge clk);
                if (mon_sel) begin
                    chk("readback_b", {16'd0, rd_data_b}, {16'd0, mon_exp});
                    mon_sel = 1'b0;
                end
                if (wr_en_o && !reset) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_write", {31'd0, wr_en_o}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("wr_addr_sb", {28'd0, wr_addr_o}, {28'd0, e.addr});
                        mon_addr = e.addr;
                        mon_exp  = (e.addr == 4'd0) ? 16'h0000 : e.data;
                        mon_sel  = 1'b1;
                    end
                end
            end
        join_none

        repeat (2) tick();
        reset = 1'b0;

        chk("rst_ready", {31'd0, wb_ready}, 32'd1);
        chk("rst_cnt", {24'd0, retired_cnt}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
        chk("rst_wr_addr", {28'd0, wr_addr_o}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_o}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            scan_b    = 4'(15 - i);
            #1;
            chk("rst_rd_a", {16'd0, rd_data_a}, 32'd0);
            chk("rst_rd_b", {16'd0, rd_data_b}, 32'd0);
        end

        // Table of single retirements.
        for (int i = 0; i < NV; i++) begin
            if (vec[i].wr) sb.push_back('{vec[i].addr, vec[i].alu});
            accept(vec[i].op, vec[i].rd, vec[i].rt, vec[i].alu);
            chk("vec_ready", {31'd0, wb_ready}, {31'd0, !vec[i].wr});
            chk("vec_wr_en", {31'd0, wr_en_o}, {31'd0, vec[i].wr});
            if (vec[i].wr) chk("vec_wr_addr", {28'd0, wr_addr_o}, {28'd0, vec[i].addr});
            chk("vec_illegal", {31'd0, illegal_o}, 32'd0);
            bump_cnt();
            tick();
            chk("vec_cnt", {24'd0, retired_cnt}, exp_cnt);
            tick();
        end

        rd_addr_a = 4'd3;
        #1;
        chk("r3_value", {16'd0, rd_data_a}, 32'h1234);
        rd_addr_a = 4'd0;
        #1;
        chk("r0_zero", {16'd0, rd_data_a}, 32'd0);

        // Response outside WAIT_MEM must be ignored.
        mem_rsp_valid = 1'b1;
        mem_rdata     = 16'hDEAD;
        tick();
        mem_rsp_valid = 1'b0;
        chk("idle_rsp_wr_en", {31'd0, wr_en_o}, 32'd0);
        chk("idle_rsp_ready", {31'd0, wb_ready}, 32'd1);

        // lwd rt=5 with a 4-cycle memory stall.
        accept(4'b0001, 4'd0, 4'd5, 16'h7777);
        chk("ld_ready", {31'd0, wb_ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("ld_wait_wr_en", {31'd0, wr_en_o}, 32'd0);
            tick();
        end
        chk("ld_wait_ready", {31'd0, wb_ready}, 32'd0);
        sb.push_back('{4'd5, 16'hBEEF});
        mem_rsp_valid = 1'b1;
        mem_rdata     = 16'hBEEF;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        chk("ld_wr_en", {31'd0, wr_en_o}, 32'd1);
        chk("ld_wr_addr", {28'd0, wr_addr_o}, 32'd5);
        bump_cnt();
        tick();
        rd_addr_a = 4'd5;
        #1;
        chk("ld_r5", {16'd0, rd_data_a}, 32'hBEEF);
        chk("ld_cnt", {24'd0, retired_cnt}, exp_cnt);

        // Back-to-back no-write accepts.
        wb_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wb_opcode = nowr_ops[k];
            chk("b2b_ready", {31'd0, wb_ready}, 32'd1);
            tick();
            bump_cnt();
            chk("b2b_wr_en", {31'd0, wr_en_o}, 32'd0);
            chk("b2b_illegal", {31'd0, illegal_o}, 32'd0);
            chk("b2b_cnt", {24'd0, retired_cnt}, exp_cnt);
        end
        wb_valid = 1'b0;
        tick();

        // Same-cycle read of the register being written.
        rd_addr_a = 4'd7;
        sb.push_back('{4'd7, 16'h00AA});
        accept(4'b1000, 4'd7, 4'd0, 16'h00AA);
        chk("byp_wr_en", {31'd0, wr_en_o}, 32'd1);
`ifdef REG_WB_BYPASS_EN
        chk("byp_same_cycle", {16'd0, rd_data_a}, 32'h00AA);
`else
        chk("byp_same_cycle", {16'd0, rd_data_a}, 32'h0000);
`endif
        bump_cnt();
        tick();
        chk("byp_next_cycle", {16'd0, rd_data_a}, 32'h00AA);
        chk("byp_cnt", {24'd0, retired_cnt}, exp_cnt);

        // Reset while waiting for memory.
        accept(4'b0001, 4'd0, 4'd2, 16'h0000);
        tick();
        chk("rw_wait_ready", {31'd0, wb_ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        exp_cnt = 0;
        chk("rw_ready", {31'd0, wb_ready}, 32'd1);
        chk("rw_cnt", {24'd0, retired_cnt}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 16'h1111;
        tick();
        mem_rsp_valid = 1'b0;
        chk("rw_late_rsp_wr_en", {31'd0, wr_en_o}, 32'd0);
        rd_addr_a = 4'd2;
        #1;
        chk("rw_r2", {16'd0, rd_data_a}, 32'd0);
        rd_addr_a = 4'd3;
        #1;
        chk("rw_r3_cleared", {16'd0, rd_data_a}, 32'd0);
        tick();
        chk("rw_wr_en_later", {31'd0, wr_en_o}, 32'd0);

        // Counter wrap.
        wb_valid  = 1'b1;
        wb_opcode = 4'b0011;
        for (int k = 0; k < (1 << CNT_W) - 1; k++) begin
            tick();
            bump_cnt();
        end
        chk("wrap_max", {24'd0, retired_cnt}, exp_cnt);
        tick();
        bump_cnt();
        wb_valid = 1'b0;
        chk("wrap_zero", {24'd0, retired_cnt}, 32'd0);
        chk("wrap_model", {24'd0, retired_cnt}, exp_cnt);

        repeat (2) tick();
        chk("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
Write-back end of the register-file datapath: it is the writer counterpart of the read-source select decoder.
- Accepts retiring instructions over a valid/ready handshake: opcode, destination fields, ALU result.
- Classifies each opcode and selects destination register and data source (ALU or memory). For lwd, waits for the memory response before writing.
- Owns the 16x16 register file storage and its two combinational read ports, which feed the operand fetch stage.

Parameters:
DATA_W, 16, register and data width
REG_AW, 4, register address width (16 registers)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
wb_valid  in  1  retiring instruction present
wb_ready  out  1  controller can accept an instruction this cycle
wb_opcode  in  4  instruction opcode
wb_rd  in  REG_AW  R-type destination field
wb_rt  in  REG_AW  I-type / load destination field
wb_alu_res  in  DATA_W  ALU result
mem_rsp_valid  in  1  load data valid
mem_rdata  in  DATA_W  load data
rd_addr_a  in  REG_AW  read port A address
rd_addr_b  in  REG_AW  read port B address
rd_data_a  out  DATA_W  read port A data
rd_data_b  out  DATA_W  read port B data
wr_en_o  out  1  register write strobe (observability)
wr_addr_o  out  REG_AW  register write address
illegal_o  out  1  one-cycle pulse: unknown opcode accepted
retired_cnt  out  CNT_W  instructions retired

Behaviour:
- Reset (synchronous) clears the following, regardless of state, and aborts any pending write:
  - all 16 registers to 0
  - state to IDLE
  - wr_en_o, illegal_o and retired_cnt to 0
  - wr_addr_o to 0
- wb_ready is high only in IDLE. An accept is wb_valid && wb_ready.
- Opcode classes:
  - R-type {1000 addreg, 1100 subreg, 1011 lnand, 1111 lor, 0000 shift}: destination wb_rd, data wb_alu_res.
  - I-type {1001, 1010, 1101, 1110, 0111, 0110}: destination wb_rt, data wb_alu_res.
  - LOAD {0001 lwd}: destination wb_rt, data mem_rdata.
  - NOWR {0010 strwd, 0100 brncheq, 0101 brnchneq, 0011 jmp}: no register write.
  - Any other opcode: no write; illegal_o pulses the cycle after accept.
- State machine IDLE / WRITE / WAIT_MEM. On accept, destination and data are captured in registers.
  - R-type / I-type: IDLE -> WRITE. In WRITE, wr_en_o=1 for exactly one cycle and the register updates at the end of that cycle; then back to IDLE. Latency from accept to visible register is 2 edges.
  - LOAD: IDLE -> WAIT_MEM. Stays there while mem_rsp_valid=0, with no timeout. On mem_rsp_valid=1, mem_rdata is captured and the controller goes to WRITE.
  - NOWR / illegal: stays in IDLE and retires immediately, so back-to-back accepts are allowed.
- mem_rsp_valid is ignored outside WAIT_MEM.
- Register 0 is hardwired zero:
  - a write to r0 still asserts wr_en_o and counts as retired, but storage is unchanged;
  - reads of r0 return 0.
- retired_cnt increments by 1 in the cycle each instruction completes: the WRITE cycle, or the accept cycle for NOWR/illegal. It wraps from 2^CNT_W-1 to 0.
- Read ports are combinational from storage. Reads during a WRITE cycle return the old value; see the optional feature for bypass.

Optional Feature:
REG_WB_BYPASS_EN
- Defined: when wr_en_o=1, wr_addr_o!=0 and rd_addr_x==wr_addr_o, rd_data_x returns the write data in that same cycle (write-through bypass).
- Undefined: rd_data_x returns the old storage value during the write cycle and the new value from the next cycle.

Decomposition:
- Package reg_wb_pkg holds:
  - all 16 opcode localparams (addreg..strwd);
  - class enum {CLS_R, CLS_I, CLS_LOAD, CLS_NOWR, CLS_ILL};
  - state enum {IDLE, WRITE, WAIT_MEM};
  - a classify function mapping opcode to class.
- Sub-module reg_file_16x16 contains storage, the r0-zero rule, two read ports and the optional bypass.
- reg_wb_ctrl contains the FSM, capture registers, counter and illegal pulse.

Test Plan:
- Reset then read all addresses on both ports -> every rd_data = 0; wb_ready=1; retired_cnt=0.
- Accept addreg, rd=3, alu=16'h1234 -> wb_ready=0 for 1 cycle, wr_en_o=1 with wr_addr_o=3; r3=16'h1234 after second edge; retired_cnt=1.
- Accept lwd, rt=5; hold mem_rsp_valid=0 for 4 cycles, then assert it with mem_rdata=16'hBEEF -> no write while waiting; r5=16'hBEEF two edges after the response.
- Accept back-to-back strwd, jmp, brncheq -> no wr_en_o; retired_cnt +3 in 3 cycles. Then opcode 4'b0100 variant and an undefined code if the map changes -> illegal_o pulses once.
- Accept addseimd, rt=0, alu=16'hFFFF -> wr_en_o=1, r0 still reads 0. With REG_WB_BYPASS_EN, write r7=16'h00AA with rd_addr_a=7 -> rd_data_a=16'h00AA in the WRITE cycle; without it, old value in that cycle.
- Assert reset while in WAIT_MEM (after accepting lwd rt=2) -> IDLE next cycle, r2 stays 0, a later mem_rsp_valid is ignored. Separately, preload retired_cnt to 16'hFFFF and retire one instruction -> count wraps to 0.
